// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner tag and
// the registered memory command.
package mem_arb_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  localparam int CMD_BE_W   = CMD_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic                  we;
    logic [CMD_DATA_W-1:0] wdata;
    logic [CMD_BE_W-1:0]   be;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection for the memory arbiter: LS wins by default, IF wins once LS
// has been granted MAX_LS_STREAK times in a row while IF was waiting.
module mem_arb_grant #(
  parameter int MAX_LS_STREAK = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic idle,
  input  logic if_req,
  input  logic ls_req,
  output logic grant_if,
  output logic grant_ls
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  logic [3:0] streak;
  logic       if_turn;

  always_comb begin
    if_turn  = (streak == STREAK_MAX) || !ls_req;
    grant_if = idle && if_req && if_turn;
    grant_ls = idle && ls_req && !grant_if;
  end

  // The streak only measures LS grants that actually made IF wait.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      streak <= '0;
    end else if (idle) begin
      if (grant_if || !if_req) begin
        streak <= '0;
      end else if (grant_ls && (streak != STREAK_MAX)) begin
        streak <= streak + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and load/store,
// one outstanding transaction, with fetch-redirect flush of an in-flight fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_if_req,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  input  logic                    i_if_flush,
  output logic                    o_if_ready,
  output logic                    o_if_rvalid,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  input  logic                    i_ls_req,
  input  logic                    i_ls_we,
  input  logic [ADDR_WIDTH-1:0]   i_ls_addr,
  input  logic [DATA_WIDTH-1:0]   i_ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_ls_be,
  output logic                    o_ls_ready,
  output logic                    o_ls_rvalid,
  output logic [DATA_WIDTH-1:0]   o_ls_rdata,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  input  logic                    i_mem_ack,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  // The command struct lives in the package, so its widths must match ours.
  if (ADDR_WIDTH != CMD_ADDR_W || DATA_WIDTH != CMD_DATA_W) begin : g_width_check
    $error("mem_port_arbiter: widths must match mem_arb_pkg command widths");
  end

  arb_state_t state, state_next;
  owner_t     owner;
  mem_cmd_t   cmd;
  logic       idle, busy, drop;
  logic       grant_if, grant_ls;
  logic       ack_if, ack_ls, if_deliver;

  assign idle = (state == IDLE) && i_reset_n;
  assign busy = (state != IDLE);

  mem_arb_grant #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_grant (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .idle     (idle),
    .if_req   (i_if_req),
    .ls_req   (i_ls_req),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    owner      = OWN_LS;
    case (state)
      IDLE: begin
        if (grant_ls)      state_next = BUSY_LS;
        else if (grant_if) state_next = BUSY_IF;
      end
      BUSY_IF: begin
        owner = OWN_IF;
        if (i_mem_ack) state_next = IDLE;
      end
      BUSY_LS: begin
        if (i_mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ack_if     = busy && i_mem_ack && (owner == OWN_IF);
  assign ack_ls     = busy && i_mem_ack && (owner == OWN_LS);
  // A flush landing on the ack cycle itself still kills the response.
  assign if_deliver = ack_if && !drop && !i_if_flush;

  // Accept: capture the command that is held on the memory port until ack.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cmd <= '0;
    end else if (grant_if) begin
      cmd <= '{addr: i_if_addr, we: 1'b0, wdata: '0, be: '1};
    end else if (grant_ls) begin
      cmd <= '{addr: i_ls_addr, we: i_ls_we, wdata: i_ls_wdata, be: i_ls_be};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      drop <= 1'b0;
    end else if (state == BUSY_IF) begin
      if (i_mem_ack)       drop <= 1'b0;
      else if (i_if_flush) drop <= 1'b1;
    end else begin
      drop <= 1'b0;
    end
  end

  // Response: one-cycle pulse after ack; data holds between pulses.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_if_rvalid <= 1'b0;
      o_ls_rvalid <= 1'b0;
      o_if_rdata  <= '0;
      o_ls_rdata  <= '0;
    end else begin
      o_if_rvalid <= if_deliver;
      o_ls_rvalid <= ack_ls;
      if (if_deliver) o_if_rdata <= i_mem_rdata;
      if (ack_ls)     o_ls_rdata <= cmd.we ? '0 : i_mem_rdata;
    end
  end

  assign o_if_ready  = grant_if;
  assign o_ls_ready  = grant_ls;
  assign o_mem_req   = busy;
  assign o_mem_we    = busy && cmd.we;
  assign o_mem_addr  = cmd.addr;
  assign o_mem_wdata = cmd.wdata;
  assign o_mem_be    = cmd.be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// model of the arbitration, flush and reset rules.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          i_reset_n, i_if_req, i_if_flush, i_ls_req, i_ls_we, i_mem_ack;
  logic [AW-1:0] i_if_addr, i_ls_addr;
  logic [DW-1:0] i_ls_wdata, i_mem_rdata;
  logic [BW-1:0] i_ls_be;
  logic          o_if_ready, o_if_rvalid, o_ls_ready, o_ls_rvalid;
  logic          o_mem_req, o_mem_we;
  logic [DW-1:0] o_if_rdata, o_ls_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [BW-1:0] o_mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LS_STREAK(MAXS)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_ready(o_if_ready), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_be(i_ls_be),
    .o_ls_ready(o_ls_ready), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  // Reference model: one outstanding transaction plus the arbitration history.
  bit          m_busy, m_own_if, m_we, m_drop;
  logic [31:0] m_addr, m_wdata, e_if_rd, e_ls_rd;
  logic [3:0]  m_be;
  bit          e_if_rv, e_ls_rv;
  int          m_streak, wait_cnt;

  // Stimulus knobs.
  bit          rst_v, if_pend, ls_pend, if_keep, ls_keep, ls_we_v, flush_v;
  bit          noise_ack, fixed_rd;
  logic [31:0] if_addr_v, ls_addr_v, ls_wdata_v, rd_val;
  logic [3:0]  ls_be_v;
  int          ack_delay;

  // Observations.
  int          tests, fails, cyc, if_pulses, ls_pulses, coincide;
  int          last_ack_ls_cyc, last_if_grant_cyc;
  bit          dut_if_rdy, dut_ls_rdy;
  bit          glog[$];
  int          gcyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit gi, gl;
    i_reset_n   = rst_v;
    i_if_req    = if_pend;
    i_if_addr   = if_addr_v;
    i_if_flush  = flush_v;
    i_ls_req    = ls_pend;
    i_ls_we     = ls_we_v;
    i_ls_addr   = ls_addr_v;
    i_ls_wdata  = ls_wdata_v;
    i_ls_be     = ls_be_v;
    i_mem_ack   = m_busy ? (wait_cnt >= ack_delay) : noise_ack;
    i_mem_rdata = fixed_rd ? rd_val : $urandom;
    #1;
    gi = rst_v && !m_busy && if_pend && (m_streak == MAXS || !ls_pend);
    gl = rst_v && !m_busy && ls_pend && !gi;
    chk("if_ready", o_if_ready, gi);
    chk("ls_ready", o_ls_ready, gl);
    dut_if_rdy = o_if_ready;
    dut_ls_rdy = o_ls_ready;
    if (gi || gl) begin
      glog.push_back(gi);
      gcyc.push_back(cyc);
      if (o_if_rvalid || o_ls_rvalid) coincide++;
    end
    if (gi) last_if_grant_cyc = cyc;
    if (rst_v && m_busy && i_mem_ack && !m_own_if) last_ack_ls_cyc = cyc;

    e_if_rv = 0;
    e_ls_rv = 0;
    if (!rst_v) begin
      m_busy = 0; m_streak = 0; m_drop = 0; wait_cnt = 0;
      m_addr = 0; m_we = 0; m_wdata = 0; m_be = 0;
      e_if_rd = 0; e_ls_rd = 0;
    end else if (!m_busy) begin
      if (gi || !if_pend) m_streak = 0;
      else if (gl && m_streak < MAXS) m_streak++;
      if (gi) begin
        m_busy = 1; m_own_if = 1; m_addr = if_addr_v; m_we = 0; m_wdata = 0;
        m_be = 4'hF; m_drop = 0; wait_cnt = 0;
      end else if (gl) begin
        m_busy = 1; m_own_if = 0; m_addr = ls_addr_v; m_we = ls_we_v;
        m_wdata = ls_wdata_v; m_be = ls_be_v; wait_cnt = 0;
      end
    end else begin
      if (m_own_if && flush_v) m_drop = 1;
      if (i_mem_ack) begin
        m_busy = 0;
        if (m_own_if) begin
          if (!m_drop) begin e_if_rv = 1; e_if_rd = i_mem_rdata; end
          m_drop = 0;
        end else begin
          e_ls_rv = 1;
          e_ls_rd = m_we ? 32'h0 : i_mem_rdata;
        end
      end else begin
        wait_cnt++;
      end
    end
    if (gi) if_pend = if_keep;
    if (gl) ls_pend = ls_keep;

    @(negedge clk);
    cyc++;
    chk("mem_req", o_mem_req, m_busy);
    chk("mem_we", o_mem_we, m_busy && m_we);
    chk("mem_addr", o_mem_addr, m_addr);
    chk("mem_wdata", o_mem_wdata, m_wdata);
    chk("mem_be", o_mem_be, m_be);
    chk("if_rvalid", o_if_rvalid, e_if_rv);
    chk("ls_rvalid", o_ls_rvalid, e_ls_rv);
    chk("if_rdata", o_if_rdata, e_if_rd);
    chk("ls_rdata", o_ls_rdata, e_ls_rd);
    if (o_if_rvalid) if_pulses++;
    if (o_ls_rvalid) ls_pulses++;
  endtask

  initial begin
    int n;
    logic [9:0] pat;
    {i_reset_n, i_if_req, i_if_flush, i_ls_req, i_ls_we, i_mem_ack} = '0;
    {i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata, i_ls_be} = '0;
    tests = 0; fails = 0; cyc = 0;
    rst_v = 0; if_pend = 0; ls_pend = 0; if_keep = 0; ls_keep = 0;
    ls_we_v = 0; flush_v = 0; noise_ack = 0; fixed_rd = 0; rd_val = 0;
    if_addr_v = 0; ls_addr_v = 0; ls_wdata_v = 0; ls_be_v = 0; ack_delay = 0;
    m_busy = 0; m_own_if = 0; m_we = 0; m_drop = 0; m_addr = 0; m_wdata = 0;
    m_be = 0; e_if_rd = 0; e_ls_rd = 0; m_streak = 0; wait_cnt = 0;
    @(negedge clk);

    // Reset state.
    step(); step();
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_if_rdata", o_if_rdata, 0);
    chk("rst_ls_rdata", o_ls_rdata, 0);
    rst_v = 1;
    step();

    // IF alone, ack on the third memory cycle.
    if_pend = 1; if_addr_v = 32'h10; ack_delay = 2; fixed_rd = 1; rd_val = 32'h1234_5678;
    if_pulses = 0; ls_pulses = 0; n = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (o_mem_req) begin
        n++;
        chk("t1_addr", o_mem_addr, 32'h10);
        chk("t1_we", o_mem_we, 0);
      end
    end
    chk("t1_req_cycles", n, 3);
    chk("t1_if_pulses", if_pulses, 1);
    chk("t1_if_rdata", o_if_rdata, 32'h1234_5678);
    chk("t1_ls_pulses", ls_pulses, 0);

    // Simultaneous requests: LS write first, IF right after the LS ack.
    glog.delete();
    if_pend = 1; if_addr_v = 32'h80;
    ls_pend = 1; ls_we_v = 1; ls_addr_v = 32'h40; ls_wdata_v = 32'hDEAD_BEEF; ls_be_v = 4'hF;
    ack_delay = 1; last_ack_ls_cyc = -100; last_if_grant_cyc = -200;
    step();
    chk("t2_ls_ready", dut_ls_rdy, 1);
    chk("t2_if_ready", dut_if_rdy, 0);
    chk("t2_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    for (int k = 0; k < 8; k++) step();
    chk("t2_if_after_ack", last_if_grant_cyc - last_ack_ls_cyc, 1);
    chk("t2_ls_rdata", o_ls_rdata, 0);

    // Continuous LS with IF pending: anti-starvation pattern.
    glog.delete();
    if_pend = 1; if_keep = 1; ls_pend = 1; ls_keep = 1; ls_we_v = 0; ack_delay = 0;
    for (int k = 0; k < 60 && glog.size() < 10; k++) step();
    if_keep = 0; ls_keep = 0; if_pend = 0; ls_pend = 0;
    chk("t3_grants", glog.size(), 10);
    pat = '0;
    for (int k = 0; k < 10; k++) pat = {pat[8:0], (k < glog.size()) ? glog[k] : 1'b0};
    chk("t3_order", pat, 10'b00001_00001);
    for (int k = 0; k < 4; k++) step();

    // Flush one cycle before ack, then a normal fetch.
    if_pend = 1; if_addr_v = 32'h20; ack_delay = 2; if_pulses = 0; rd_val = 32'h5555_0000;
    step(); step();
    flush_v = 1; step();
    flush_v = 0; step(); step();
    chk("t4_flushed_pulses", if_pulses, 0);
    if_pend = 1; if_addr_v = 32'h24; rd_val = 32'hAAAA_5555;
    for (int k = 0; k < 6; k++) step();
    chk("t4_next_pulses", if_pulses, 1);
    chk("t4_next_rdata", o_if_rdata, 32'hAAAA_5555);

    // Reset in the middle of an LS read.
    ls_pend = 1; ls_we_v = 0; ls_addr_v = 32'h100; ack_delay = 20;
    step(); step(); step();
    chk("t5_busy", o_mem_req, 1);
    rst_v = 0; ls_pend = 0; ls_pulses = 0;
    step();
    chk("t5_req_after_rst", o_mem_req, 0);
    chk("t5_addr_after_rst", o_mem_addr, 0);
    rst_v = 1; if_pend = 1; if_addr_v = 32'h200; ack_delay = 1;
    step();
    chk("t5_if_ready", dut_if_rdy, 1);
    for (int k = 0; k < 5; k++) step();
    chk("t5_no_ls_pulse", ls_pulses, 0);

    // Zero-wait memory, back-to-back fetches.
    gcyc.delete(); coincide = 0;
    if_pend = 1; if_keep = 1; ack_delay = 0;
    for (int k = 0; k < 9; k++) step();
    if_keep = 0; if_pend = 0;
    for (int k = 0; k < 3; k++) step();
    chk("t6_grants", gcyc.size(), 5);
    for (int k = 0; k + 1 < gcyc.size(); k++) chk("t6_spacing", gcyc[k+1] - gcyc[k], 2);
    chk("t6_coincide", coincide, gcyc.size() - 1);

    // Randomized traffic with flushes, idle-ack noise and occasional resets.
    fixed_rd = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!if_pend && ($urandom % 3 == 0)) begin
        if_pend = 1; if_addr_v = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_pend && ($urandom % 3 == 0)) begin
        ls_pend = 1; ls_we_v = $urandom % 2; ls_addr_v = $urandom;
        ls_wdata_v = $urandom; ls_be_v = 4'($urandom);
      end
      ack_delay = $urandom % 4;
      noise_ack = $urandom % 2;
      flush_v = ($urandom % 6 == 0);
      rst_v = ($urandom % 200 != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the instruction-fetch stage (IF) and the load/store unit (LS).
- Accepts one transaction at a time and drives the memory port until the memory acknowledges.
- Returns read data, or write completion, to the owning requester.
- Supports fetch-redirect flush of an in-flight fetch, and includes an anti-starvation guard for IF.

Parameters:
- ADDR_WIDTH, 32, byte address width for all ports.
- DATA_WIDTH, 32, data/instruction width.
- MAX_LS_STREAK, 4, maximum consecutive LS grants while IF is waiting; range 1..15.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous active-low reset
- i_if_req  in  1  IF read request; held until accepted
- i_if_addr  in  ADDR_WIDTH  IF fetch address
- i_if_flush  in  1  fetch redirect; discards in-flight IF response
- o_if_ready  out  1  IF request accepted this cycle (combinational)
- o_if_rvalid  out  1  IF read data valid (1-cycle pulse)
- o_if_rdata  out  DATA_WIDTH  instruction word
- i_ls_req  in  1  LS request; held until accepted
- i_ls_we  in  1  1 = write, 0 = read
- i_ls_addr  in  ADDR_WIDTH  LS address
- i_ls_wdata  in  DATA_WIDTH  write data
- i_ls_be  in  DATA_WIDTH/8  byte enables (writes only)
- o_ls_ready  out  1  LS request accepted this cycle (combinational)
- o_ls_rvalid  out  1  LS read data valid or write complete (1-cycle pulse)
- o_ls_rdata  out  DATA_WIDTH  load data; 0 for writes
- o_mem_req  out  1  memory command valid; held until i_mem_ack
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- o_mem_be  out  DATA_WIDTH/8  memory byte enables
- i_mem_ack  in  1  memory completion; read data valid in the same cycle
- i_mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- States: IDLE, BUSY_IF, BUSY_LS.
- Acceptance happens only in IDLE. The ready output of the selected requester is high the same cycle; the other requester's ready is low.
- Default grant priority is LS over IF. If the streak counter equals MAX_LS_STREAK and i_if_req is high, IF wins.
- Streak counter:
  - increments on each LS grant made while i_if_req is high;
  - clears on IF grant, and on any IDLE cycle where i_if_req is low;
  - saturates at MAX_LS_STREAK.
- Accept in cycle N:
  - the command (address, we, wdata, be; IF forces we=0, be=all-ones) is registered;
  - state moves to BUSY_x;
  - o_mem_req is high from N+1 and all o_mem_* stay stable until i_mem_ack.
- On the i_mem_ack cycle A:
  - o_mem_req drops at A+1;
  - state returns to IDLE at A+1;
  - the owner's rvalid pulses at A+1 with registered rdata.
- A new acceptance is allowed at A+1. Minimum spacing between acceptances is 2 cycles.
- i_mem_ack is ignored in IDLE.
- Flush:
  - i_if_flush high in any cycle while in BUSY_IF sets a drop flag.
  - The memory transaction still completes. o_if_rvalid is suppressed at A+1 and the flag clears.
  - Flush in IDLE, or in BUSY_LS, has no effect.
  - Flush does not gate o_if_ready; the requester deasserts i_if_req itself.
- rdata outputs hold their last value between pulses. They are 0 after reset.
- Reset (any cycle, including mid-transaction):
  - state IDLE, streak 0, drop flag 0;
  - o_mem_req, o_mem_we, o_if_rvalid, o_ls_rvalid low at the next edge;
  - all data/address outputs 0;
  - any outstanding transaction is abandoned.

Decomposition:
- Package mem_arb_pkg contains:
  - arb_state_t enum (IDLE, BUSY_IF, BUSY_LS);
  - owner_t enum (OWN_IF, OWN_LS);
  - mem_cmd_t struct (addr, we, wdata, be).
- One sub-module, mem_arb_grant: combinational priority select plus streak counter register. It outputs grant_if/grant_ls.

Test Plan:
- IF only, address 0x10, memory ack after 3 cycles → o_mem_req high for 3 cycles with addr 0x10, we=0; o_if_rvalid pulses once with the returned word; o_ls_rvalid stays low.
- IF and LS requesting together in IDLE, LS write 0xDEADBEEF to 0x40 with be=0xF → LS accepted first (o_ls_ready=1, o_if_ready=0); IF accepted on the cycle after the LS ack; o_ls_rdata=0.
- LS held continuously requesting with IF pending, MAX_LS_STREAK=4 → grant order LS,LS,LS,LS,IF,LS…; counter clears after the IF grant.
- IF accepted, i_if_flush pulsed 1 cycle before ack → o_mem_req completes normally; o_if_rvalid stays low; the next IF fetch returns data normally.
- Reset asserted while in BUSY_LS with o_mem_req high → next cycle o_mem_req=0, state IDLE, no rvalid; a fresh IF request is accepted immediately after reset release.
- Back-to-back with ack in the first o_mem_req cycle (zero-wait memory) → acceptances every 2 cycles; rvalid and new ready coincide in the same cycle.
